ps_conv3x3_filter: RTL
======================

Name: ps_conv3x3_filter

Overview:
- Parametrised 3x3 streaming convolution stage for the pixel-stream (ps_) pipeline, successor to the fixed Gaussian stage.
- Owns its own line buffering and window formation.
- Adds runtime mode select (bypass / Gaussian / sharpen / edge), downstream backpressure, and parametrised pixel width and image geometry.
- Sits between the capture/colour-convert stage and the frame-buffer writer.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 640: pixels per line; must be >= 3.
- IMG_H, 480: lines per frame; must be >= 3.

Ports:
- i_clk  input  1  pixel clock, rising-edge.
- i_rst  input  1  synchronous reset, active-high.
- i_mode  input  2  filter mode: 00 bypass, 01 Gaussian, 10 sharpen, 11 edge.
- i_data  input  DATA_W  input pixel, raster order.
- i_valid  input  1  input pixel valid.
- o_ready  output  1  stage can accept a pixel; equal to i_ready.
- o_data  output  DATA_W  filtered pixel.
- o_valid  output  1  o_data valid.
- i_ready  input  1  downstream ready.

Behaviour:
- Handshake:
  - Input beat accepted when i_valid & o_ready.
  - Output beat consumed when o_valid & i_ready.
  - Pipeline enable en = i_ready. When en=0, every pipeline register, counter and line buffer holds, and o_data/o_valid are held stable.
- Reset: synchronous, active-high. Required reset state:
  - o_valid=0, o_data=0.
  - col/row counters = 0.
  - mode latch = 00.
  - All pipeline valid bits = 0.
  - Line-buffer contents are don't-care; output validity is gated by the counters.
  - Reset asserted mid-frame drops the partial frame. The next accepted pixel is treated as (row 0, col 0).
- Counters:
  - col counts 0..IMG_W-1 on accepted beats; at IMG_W-1 it wraps to 0 and row increments.
  - row wraps to 0 after (IMG_H-1, IMG_W-1).
- Mode latch: i_mode is sampled only on the accepted beat at (row 0, col 0). Mode changes mid-frame take effect at the next frame.
- Window:
  - Two line buffers of depth IMG_W hold the previous two lines.
  - A 3x3 shift window advances on each accepted beat.
  - Window is complete when row>=2 and col>=2; its centre is pixel (row-1, col-1).
  - No border replication.
- Filter modes (all intermediates are signed, DATA_W+5 bits):
  - 01 Gaussian: (1 2 1 / 2 4 2 / 1 2 1) sum, shifted right 4 (truncate).
  - 10 sharpen: 5*centre - N - S - E - W, clamped to [0, 2^DATA_W-1].
  - 11 edge: |Gx|+|Gy| (Sobel), clamped to 2^DATA_W-1.
- Latency and output count (filter modes):
  - Output occurs 2 enabled cycles after the accepted beat that completes a window: stage 1 = products/partial sums, stage 2 = final sum/clamp into o_data.
  - Exactly (IMG_W-2)*(IMG_H-2) outputs per frame.
- Bypass (00): o_data = accepted i_data, 1 enabled cycle later. IMG_W*IMG_H outputs per frame, no window gating.
- Simultaneous events:
  - Accepted beat at (IMG_H-1, IMG_W-1) with a new frame's first beat next cycle: the filter-mode tail outputs of the old frame are still emitted in order, then the mode latch updates.
  - i_valid=1 with i_ready=0: nothing accepted; the input beat must be held by upstream.

Optional Feature:
- Macro: PS_CONV_SAT_STATS_EN.
- Defined:
  - Adds output port o_sat_cnt (32 bits).
  - It counts output beats whose clamp engaged (sharpen/edge) in the current frame.
  - It clears at the accepted (row 0, col 0) beat and at reset.
  - It saturates at all-ones.
- Undefined: no port and no counter logic.

Decomposition:
- Package ps_conv_pkg:
  - mode constants MODE_BYPASS/MODE_GAUSS/MODE_SHARP/MODE_EDGE.
  - accumulator width function ACC_W(DATA_W) = DATA_W+5.
  - Gaussian shift constant 4.
- Sub-module ps_line_buffer: parametrised depth and width, single-port read-before-write, advance on enable. Instantiated twice.

Test Plan:
- Bypass, IMG_W=8, IMG_H=4, ramp 0..31, i_ready=1: 32 outputs equal to the inputs, each 1 cycle after acceptance.
- Gaussian, flat image of value 100: 6x2=12 outputs, all 100. The first output arrives 2 cycles after the accepted beat at (2,2).
- Sharpen, single centre pixel 255 on a 0 background: output at that centre = 255 (clamped from 1275). Outputs at the N/S/E/W neighbours = 0 (clamped from -255).
- Edge, vertical step 0|200 (DATA_W=8): Sobel value 800 at the columns spanning the step, so o_data = 255 there; flat regions give 0.
- Backpressure: random i_ready at 50% duty with continuous input. Output sequence is identical to the i_ready=1 run, and o_data/o_valid are stable while i_ready=0.
- Reset asserted at (2,3) mid-frame, then a full new frame in mode 01: no stale outputs; the output count equals exactly 12 for the 8x4 frame. With PS_CONV_SAT_STATS_EN, o_sat_cnt = 0 after reset.

Source files
------------

// File: rtl/ps_conv_pkg.sv
// Shared constants and helpers for the ps_ 3x3 convolution stage.
// Mode encodings, accumulator width and Gaussian normalisation shift.
package ps_conv_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_GAUSS  = 2'b01;
    localparam logic [1:0] MODE_SHARP  = 2'b10;
    localparam logic [1:0] MODE_EDGE   = 2'b11;

    localparam int GAUSS_SHIFT = 4;

    function automatic int ACC_W(input int data_w);
        return data_w + 5;
    endfunction

endpackage

// File: rtl/ps_line_buffer.sv
// One image line of delay for the 3x3 window.
// Read-before-write: o_data is the word about to be overwritten.
module ps_line_buffer
    import ps_conv_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    assign o_data = mem[ptr];

    // pointer walks the line in step with accepted beats
    always_ff @(posedge i_clk) begin
        if (i_rst) ptr <= '0;
        else if (i_en) ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end

    // storage needs no reset; validity comes from the frame counters
    always_ff @(posedge i_clk) begin
        if (i_en) mem[ptr] <= i_data;
    end

endmodule

// File: rtl/ps_conv3x3_filter.sv
// Streaming 3x3 convolution: bypass / Gaussian / sharpen / Sobel edge.
// Optional clamp statistics port under macro PS_CONV_SAT_STATS_EN.
module ps_conv3x3_filter
    import ps_conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready
`ifdef PS_CONV_SAT_STATS_EN
    ,
    output logic [31:0]       o_sat_cnt
`endif
);

    localparam int AW = ACC_W(DATA_W);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic signed [AW-1:0] PIX_MAX =
        $signed({{(AW-DATA_W){1'b0}}, {DATA_W{1'b1}}});

    logic              en, acc, first, win_ok, byp, filt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [1:0]        mode_q, cur_mode;
    logic [DATA_W-1:0] lb0_q, lb1_q;
    logic [DATA_W-1:0] w  [3][3];
    logic [DATA_W-1:0] wn [3][3];
    logic signed [AW-1:0] x [3][3];
    logic signed [AW-1:0] gx, gy, p0_d, p1_d, p0, p1, sum;
    logic              s1_valid, s1_pass;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_pix, filt_px;
    logic              clamp_lo, clamp_hi;

    assign en       = i_ready;
    assign o_ready  = i_ready;
    assign acc      = i_valid & i_ready;
    assign first    = (col == '0) && (row == '0);
    assign cur_mode = first ? i_mode : mode_q;
    assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
    assign byp      = acc && (cur_mode == MODE_BYPASS);
    assign filt     = acc && (cur_mode != MODE_BYPASS) && win_ok;

    ps_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(acc),
        .i_data(i_data), .o_data(lb0_q)
    );

    ps_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(acc),
        .i_data(lb0_q), .o_data(lb1_q)
    );

    // raster position and per-frame mode latch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col    <= '0;
            row    <= '0;
            mode_q <= MODE_BYPASS;
        end else if (acc) begin
            if (first) mode_q <= i_mode;
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // next window: shift left, new column enters on the right
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) wn[r][c] = w[r][c+1];
        end
        wn[0][2] = lb1_q;
        wn[1][2] = lb0_q;
        wn[2][2] = i_data;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++)
                x[r][c] = $signed({{(AW-DATA_W){1'b0}}, wn[r][c]});
        end
    end

    // window registers advance only on accepted beats
    always_ff @(posedge i_clk) begin
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) w[r][c] <= wn[r][c];
            end
        end
    end

    // stage-1 partial sums per mode
    always_comb begin
        gx = (x[0][2] + (x[1][2] <<< 1) + x[2][2])
           - (x[0][0] + (x[1][0] <<< 1) + x[2][0]);
        gy = (x[2][0] + (x[2][1] <<< 1) + x[2][2])
           - (x[0][0] + (x[0][1] <<< 1) + x[0][2]);
        p0_d = '0;
        p1_d = '0;
        case (cur_mode)
            MODE_GAUSS: begin
                p0_d = x[0][0] + (x[0][1] <<< 1) + x[0][2]
                     + x[2][0] + (x[2][1] <<< 1) + x[2][2];
                p1_d = (x[1][0] <<< 1) + (x[1][1] <<< 2) + (x[1][2] <<< 1);
            end
            MODE_SHARP: begin
                p0_d = (x[1][1] <<< 2) + x[1][1];
                p1_d = x[0][1] + x[2][1] + x[1][0] + x[1][2];
            end
            MODE_EDGE: begin
                p0_d = gx[AW-1] ? -gx : gx;
                p1_d = gy[AW-1] ? -gy : gy;
            end
            default: ;
        endcase
    end

    // stage 1: filter partials, or a bypass pixel queued behind a tail result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= filt || (byp && s1_valid);
            s1_pass  <= byp;
            s1_mode  <= cur_mode;
            s1_pix   <= i_data;
            p0       <= p0_d;
            p1       <= p1_d;
        end
    end

    // stage-2 final sum, normalise and clamp
    always_comb begin
        sum = (s1_mode == MODE_SHARP) ? p0 - p1 : p0 + p1;
        if (s1_mode == MODE_GAUSS) sum = sum >>> GAUSS_SHIFT;
        clamp_lo = (sum < 0);
        clamp_hi = (sum > PIX_MAX);
        if (clamp_lo) filt_px = '0;
        else if (clamp_hi) filt_px = '1;
        else filt_px = sum[DATA_W-1:0];
    end

    // output register: older stage-1 entry wins, else direct bypass
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (en) begin
            if (s1_valid) begin
                o_valid <= 1'b1;
                o_data  <= s1_pass ? s1_pix : filt_px;
            end else if (byp) begin
                o_valid <= 1'b1;
                o_data  <= i_data;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef PS_CONV_SAT_STATS_EN
    logic sat;
    assign sat = (clamp_lo || clamp_hi) && s1_valid && !s1_pass &&
                 ((s1_mode == MODE_SHARP) || (s1_mode == MODE_EDGE));

    // per-frame count of clamped outputs, saturating at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) o_sat_cnt <= '0;
        else if (acc && first) o_sat_cnt <= '0;
        else if (en && sat && (o_sat_cnt != '1)) o_sat_cnt <= o_sat_cnt + 1;
    end
`endif

endmodule
